grs_nonce_filter: RTL and testbench



---
 rtl/grs_nonce_filter.sv | 128 ++++++++++++
 tb/tb_grs_nonce_filter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grs_nonce_filter.sv
// grs_nonce_filter: tracks nonces alongside the Groestl-512 pipeline, flags hashes
// whose top 64 bits are <= target, and queues the winning nonces for the host.
// Optional feature macro: GRS_HASH_COUNT_EN enables the checked-hash counter;
// without it hash_count is tied to zero.
module grs_nonce_filter #(
    parameter int unsigned LATENCY = 32,
    parameter int unsigned DEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [31:0]  nonce_in,
    input  logic [511:0] hash,
    input  logic [63:0]  target,
    output logic         out_valid,
    output logic [31:0]  out_nonce,
    input  logic         out_ready,
    output logic         overflow,
    output logic [31:0]  hash_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [LATENCY-1:0] dl_valid;
    logic [31:0]        dl_nonce [LATENCY];
    logic               tap_valid;
    logic [31:0]        tap_nonce;
    logic               tap_match;

    logic               cmp_match;
    logic [31:0]        cmp_nonce;

    logic [31:0]        mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push;

    // Lower hash bits play no part in the difficulty test.
    logic               unused_hash_bits;
    assign unused_hash_bits = ^hash[447:0];

    assign tap_valid = dl_valid[LATENCY-1];
    assign tap_nonce = dl_nonce[LATENCY-1];
    assign tap_match = tap_valid && (hash[511:448] <= target);

    // Delay-line valid bits: cleared on reset so fill slots and bubbles never match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= in_valid;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
            end
        end
    end

    // Delay-line nonce data: no reset needed, qualified by the valid bits.
    always_ff @(posedge clk) begin
        dl_nonce[0] <= nonce_in;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            dl_nonce[i] <= dl_nonce[i-1];
        end
    end

    // Compare stage: registers the match decision with its nonce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_match <= 1'b0;
            cmp_nonce <= '0;
        end else begin
            cmp_match <= tap_match;
            cmp_nonce <= tap_nonce;
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid  = !fifo_empty;
    assign out_nonce  = mem[rd_ptr[AW-1:0]];
    assign pop        = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push       = cmp_match && (!fifo_full || pop);

    // Golden-nonce FIFO storage, pointers and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= cmp_nonce;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (cmp_match && !push) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef GRS_HASH_COUNT_EN
    logic [31:0] hash_count_q;

    // Counts every valid tap, golden or not; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hash_count_q <= '0;
        end else if (tap_valid) begin
            hash_count_q <= hash_count_q + 32'd1;
        end
    end

    assign hash_count = hash_count_q;
`else
    assign hash_count = '0;
`endif

endmodule

// File: tb/tb_grs_nonce_filter.sv
// Self-checking bench for grs_nonce_filter: a transaction-level model (in-flight
// queue keyed by due cycle, FIFO queue) is compared against the DUT every cycle,
// with directed scenarios adding literal expectations.
module tb_grs_nonce_filter;
    localparam int unsigned L = 32;
    localparam int unsigned D = 4;
    localparam logic [63:0] T = 64'h0000_00FF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  nonce_in = '0;
    logic [511:0] hash = '0;
    logic [63:0]  target = T;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [31:0]  out_nonce;
    logic         overflow;
    logic [31:0]  hash_count;

    always #5 clk = ~clk;

    grs_nonce_filter #(.LATENCY(L), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .nonce_in(nonce_in),
        .hash(hash), .target(target), .out_valid(out_valid), .out_nonce(out_nonce),
        .out_ready(out_ready), .overflow(overflow), .hash_count(hash_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned  mc = 0;
    int unsigned  due_q[$];
    logic [31:0]  inf_q[$];
    logic [31:0]  fifo_q[$];
    bit           ovf_m = 1'b0;
    bit           pend_m = 1'b0;
    logic [31:0]  pend_n = '0;
    logic [31:0]  cnt_m = '0;
    bit           tap_m;
    bit           match_m;
    logic [31:0]  tn_m;

    task automatic model_clear();
        due_q.delete();
        inf_q.delete();
        fifo_q.delete();
        ovf_m  = 1'b0;
        pend_m = 1'b0;
        cnt_m  = '0;
    endtask

    always @(posedge reset) model_clear();

    always @(posedge clk) begin
        if (reset) begin
            model_clear();
        end else begin
            tap_m = 1'b0;
            tn_m  = '0;
            if (due_q.size() != 0 && due_q[0] == mc) begin
                tap_m = 1'b1;
                tn_m  = inf_q[0];
                void'(due_q.pop_front());
                void'(inf_q.pop_front());
            end
            match_m = tap_m && (hash[511:448] <= target);
            if (fifo_q.size() != 0 && out_ready) void'(fifo_q.pop_front());
            if (pend_m) begin
                if (fifo_q.size() < D) fifo_q.push_back(pend_n);
                else ovf_m = 1'b1;
            end
            pend_m = match_m;
            pend_n = tn_m;
            if (tap_m) cnt_m = cnt_m + 32'd1;
            if (in_valid) begin
                due_q.push_back(mc + L);
                inf_q.push_back(nonce_in);
            end
        end
        mc++;
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, fifo_q.size() != 0);
        if (fifo_q.size() != 0) chk("out_nonce", out_nonce, fifo_q[0]);
        chk("overflow", overflow, ovf_m);
`ifdef GRS_HASH_COUNT_EN
        chk("hash_count", hash_count, cnt_m);
`else
        chk("hash_count", hash_count, 32'd0);
`endif
    end

    // ---------------- stimulus ----------------
    logic [63:0] plan [int unsigned];
    logic [63:0] def_top = '1;

    task automatic drive(input bit iv, input logic [31:0] n, input logic [63:0] top, input bit rdy);
        logic [63:0] ht;
        @(posedge clk); #1;
        ht = def_top;
        if (plan.exists(mc)) begin
            ht = plan[mc];
            plan.delete(mc);
        end
        hash      = {ht, {14{$urandom()}}};
        in_valid  = iv;
        nonce_in  = n;
        out_ready = rdy;
        if (iv) plan[mc + L] = top;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom(), '1, rdy);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, '1, 1'b0);
        reset = 1'b1;
        idle(2, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] tr;
        logic [63:0] top;
        int unsigned r;

        idle(3, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_nonce", out_nonce, 32'h0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_hash_count", hash_count, 32'h0);

        // Bubbles: all-zero hash, all-ones target, nothing valid.
        target  = '1;
        def_top = '0;
        idle(40, 1'b0);
        @(negedge clk);
        chk("bubble_out_valid", out_valid, 1'b0);
        chk("bubble_hash_count", hash_count, 32'h0);
        def_top = '1;
        target  = T;

        // Single hit: out_valid rises exactly L+2 cycles after input.
        drive(1'b1, 32'h1234_5678, 64'h0000_0012_0000_0000, 1'b0);
        idle(L + 1, 1'b0);
        @(negedge clk);
        chk("hit_not_early", out_valid, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        chk("hit_out_valid", out_valid, 1'b1);
        chk("hit_out_nonce", out_nonce, 32'h1234_5678);
        idle(1, 1'b1);
        idle(1, 1'b0);
        @(negedge clk);
        chk("hit_popped", out_valid, 1'b0);

        // Boundary: equal is golden, target+1 is not, target=0/hash=0 is golden.
        drive(1'b1, 32'hA, T, 1'b0);
        drive(1'b1, 32'hB, T + 64'd1, 1'b0);
        idle(L + 1, 1'b0);
        @(negedge clk);
        chk("eq_golden_valid", out_valid, 1'b1);
        chk("eq_golden_nonce", out_nonce, 32'hA);
        idle(1, 1'b1);
        idle(1, 1'b0);
        @(negedge clk);
        chk("plus1_not_golden", out_valid, 1'b0);
        target = '0;
        drive(1'b1, 32'hC, 64'h0, 1'b0);
        idle(L + 2, 1'b0);
        @(negedge clk);
        chk("zero_target_valid", out_valid, 1'b1);
        chk("zero_target_nonce", out_nonce, 32'hC);
        idle(1, 1'b1);
        target = T;

        // Overflow: six golden nonces into a 4-deep FIFO with no pops.
        do_reset();
        for (int i = 1; i <= 6; i++) drive(1'b1, i, 64'h0, 1'b0);
        idle(L + 2, 1'b0);
        @(negedge clk);
        chk("ovf_set", overflow, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            drive(1'b0, 32'h0, '1, 1'b1);
            @(negedge clk);
            chk("ovf_drain", out_nonce, j);
        end
        drive(1'b0, 32'h0, '1, 1'b0);
        @(negedge clk);
        chk("ovf_drained_empty", out_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // Full FIFO with a pop coinciding with the 5th push: no drop.
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, i, 64'h0, 1'b0);
        idle(L, 1'b0);
        drive(1'b0, 32'h0, '1, 1'b1);
        drive(1'b0, 32'h0, '1, 1'b0);
        @(negedge clk);
        chk("pop_push_no_ovf", overflow, 1'b0);
        for (int j = 2; j <= 5; j++) begin
            drive(1'b0, 32'h0, '1, 1'b1);
            @(negedge clk);
            chk("pop_push_drain", out_nonce, j);
        end

        // Reset mid-run: 2 queued, 10 in flight.
        do_reset();
        for (int i = 1; i <= 12; i++) drive(1'b1, 32'h100 + i, 64'h0, 1'b0);
        idle(L - 8, 1'b0);
        #1;
        chk("pre_reset_queued", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_out_nonce", out_nonce, 32'h0);
        idle(2, 1'b0);
        reset = 1'b0;
        idle(L + 10, 1'b0);
        @(negedge clk);
        chk("post_reset_silent", out_valid, 1'b0);

        // Randomised traffic against the model.
        tr = 64'h0000_8000_0000_0000;
        target = tr;
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: top = tr;
                1: top = tr + 64'd1;
                2: top = tr >> $urandom_range(1, 8);
                3: top = {$urandom(), $urandom()};
                default: top = '1;
            endcase
            drive($urandom_range(0, 2) != 0, $urandom(), top, $urandom_range(0, 1) == 1);
            if (k % 250 == 249) begin
                tr = {1'b0, $urandom_range(1, 32'h7FFF_FFFF), $urandom()};
                target = tr;
            end
        end
        idle(L + 8, 1'b1);

`ifdef GRS_HASH_COUNT_EN
        // Counter wrap from a preloaded value.
        do_reset();
        idle(4, 1'b1);
        @(negedge clk);
        #1;
        force dut.hash_count_q = 32'hFFFF_FFFE;
        release dut.hash_count_q;
        cnt_m = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) drive(1'b1, i, '1, 1'b1);
        idle(L - 1, 1'b1);
        @(negedge clk);
        chk("wrap_ffffffff", hash_count, 32'hFFFF_FFFF);
        idle(1, 1'b1);
        @(negedge clk);
        chk("wrap_zero", hash_count, 32'h0);
        idle(1, 1'b1);
        @(negedge clk);
        chk("wrap_one", hash_count, 32'h1);
        idle(4, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
